// File: rtl/xalu_mdu_ctrl.sv
// xalu_mdu_ctrl: execute-stage multiply/divide sequencer and HI/LO owner.
// Multiply-class ops run for MUL_LAT cycles; divides use a 32-step
// restoring divider followed by one sign-fix cycle.
// Optional feature macro: XALU_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
module xalu_mdu_ctrl #(
   parameter int MUL_LAT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   input  logic [3:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mul_res,
   output logic        done
);

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_DIV   = 4'd2;
   localparam logic [3:0] OP_DIVU  = 4'd3;
   localparam logic [3:0] OP_MTHI  = 4'd4;
   localparam logic [3:0] OP_MTLO  = 4'd5;
   localparam logic [3:0] OP_MUL   = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd8;
   localparam logic [3:0] OP_MADDU = 4'd9;
   localparam logic [3:0] OP_MSUB  = 4'd10;
   localparam logic [3:0] OP_MSUBU = 4'd11;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  cnt_reg;
   logic [3:0]  op_reg;
   logic [63:0] prod_reg;
   logic [31:0] rem_reg, quot_reg, dvsr_reg, dvnd_reg;
   logic        neg_q_reg, neg_r_reg, dz_reg;

   logic        is_mul_class, is_div, op_legal, signed_op, accept;
   logic        mul_last, div_last;
   logic [63:0] ext_a, ext_b, prod;
   logic [31:0] abs_a, abs_b;
   logic [32:0] shifted, diff;

   // Decode the presented op: legality, class and signedness
   always_comb begin
      is_mul_class = 1'b0;
      is_div       = 1'b0;
      op_legal     = 1'b0;
      signed_op    = 1'b0;
      case (op)
         OP_MULT:  begin op_legal = 1'b1; is_mul_class = 1'b1; signed_op = 1'b1; end
         OP_MULTU: begin op_legal = 1'b1; is_mul_class = 1'b1; end
         OP_DIV:   begin op_legal = 1'b1; is_div = 1'b1; signed_op = 1'b1; end
         OP_DIVU:  begin op_legal = 1'b1; is_div = 1'b1; end
         OP_MTHI,
         OP_MTLO:  op_legal = 1'b1;
         OP_MUL:   begin op_legal = 1'b1; is_mul_class = 1'b1; signed_op = 1'b1; end
`ifdef XALU_MADD_EN
         OP_MADD,
         OP_MSUB:  begin op_legal = 1'b1; is_mul_class = 1'b1; signed_op = 1'b1; end
         OP_MADDU,
         OP_MSUBU: begin op_legal = 1'b1; is_mul_class = 1'b1; end
`endif
         default:  op_legal = 1'b0;
      endcase
   end

   assign accept   = op_valid && !flush && (state_reg == S_IDLE) && op_legal;
   assign mul_last = (state_reg == S_MUL) && (cnt_reg == 5'(MUL_LAT - 1));
   assign div_last = (state_reg == S_DIV) && (cnt_reg == 5'd31);
   assign busy     = (state_reg != S_IDLE);

   // Operand extension, full product and magnitudes computed from the issue operands
   always_comb begin
      ext_a   = signed_op ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
      ext_b   = signed_op ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
      prod    = ext_a * ext_b;
      abs_a   = (signed_op && op_a[31]) ? (32'd0 - op_a) : op_a;
      abs_b   = (signed_op && op_b[31]) ? (32'd0 - op_b) : op_b;
      shifted = {rem_reg, quot_reg[31]};
      diff    = shifted - {1'b0, dvsr_reg};
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (accept) begin
            if (is_mul_class)    state_next = S_MUL;
            else if (is_div)     state_next = (op_b == 32'd0) ? S_FIX : S_DIV;
         end
         S_MUL:  if (mul_last) state_next = S_IDLE;
         S_DIV:  if (div_last) state_next = S_FIX;
         S_FIX:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_reg <= S_IDLE;
      else       state_reg <= state_next;
   end

   // Datapath: operand capture, divider iteration and result retirement
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg   <= '0;
         op_reg    <= '0;
         prod_reg  <= '0;
         rem_reg   <= '0;
         quot_reg  <= '0;
         dvsr_reg  <= '0;
         dvnd_reg  <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
         dz_reg    <= 1'b0;
         hi        <= '0;
         lo        <= '0;
         mul_res   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            S_IDLE: if (accept) begin
               cnt_reg   <= '0;
               op_reg    <= op;
               prod_reg  <= prod;
               rem_reg   <= '0;
               quot_reg  <= abs_a;
               dvsr_reg  <= abs_b;
               dvnd_reg  <= op_a;
               neg_q_reg <= signed_op && (op_a[31] ^ op_b[31]);
               neg_r_reg <= signed_op && op_a[31];
               dz_reg    <= (op_b == 32'd0);
               if (op == OP_MTHI) hi <= op_a;
               if (op == OP_MTLO) lo <= op_a;
            end
            S_MUL: begin
               cnt_reg <= cnt_reg + 5'd1;
               if (mul_last) begin
                  done <= 1'b1;
                  case (op_reg)
                     OP_MUL: mul_res <= prod_reg[31:0];
`ifdef XALU_MADD_EN
                     OP_MADD,
                     OP_MADDU: {hi, lo} <= {hi, lo} + prod_reg;
                     OP_MSUB,
                     OP_MSUBU: {hi, lo} <= {hi, lo} - prod_reg;
`endif
                     default: {hi, lo} <= prod_reg;
                  endcase
               end
            end
            S_DIV: begin
               cnt_reg <= cnt_reg + 5'd1;
               // Restoring step: keep the trial difference only if it did not go negative
               if (!diff[32]) begin
                  rem_reg  <= diff[31:0];
                  quot_reg <= {quot_reg[30:0], 1'b1};
               end else begin
                  rem_reg  <= shifted[31:0];
                  quot_reg <= {quot_reg[30:0], 1'b0};
               end
            end
            S_FIX: begin
               done <= 1'b1;
               if (dz_reg) begin
                  hi <= dvnd_reg;
                  lo <= 32'hFFFF_FFFF;
               end else begin
                  lo <= neg_q_reg ? (32'd0 - quot_reg) : quot_reg;
                  hi <= neg_r_reg ? (32'd0 - rem_reg) : rem_reg;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xalu_mdu_ctrl.sv
// Directed self-checking bench for xalu_mdu_ctrl (MUL_LAT = 3).
module tb_xalu_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [3:0]  op;
   logic [31:0] op_a, op_b;
   logic        flush;
   logic        busy, done;
   logic [31:0] hi, lo, mul_res;

   int checks   = 0;
   int failures = 0;
   logic proto_viol = 1'b0;

   xalu_mdu_ctrl #(.MUL_LAT(3)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
      .op_a(op_a), .op_b(op_b), .flush(flush), .busy(busy),
      .hi(hi), .lo(lo), .mul_res(mul_res), .done(done)
   );

   always #5 clk = ~clk;

   // Issue while busy must never happen
   always @(posedge clk) if (op_valid && busy) proto_viol <= 1'b1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present an op for one edge, then count busy cycles until the result appears
   task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic fl, input int exp_busy,
                         input logic exp_done);
      int n;
      logic early_done;
      @(negedge clk);
      op_valid = 1'b1; op = c; op_a = a; op_b = b; flush = fl;
      @(posedge clk); #1;
      op_valid = 1'b0; flush = 1'b0;
      n = 0; early_done = 1'b0;
      while (busy === 1'b1 && n < 100) begin
         if (done !== 1'b0) early_done = 1'b1;
         n++;
         @(posedge clk); #1;
      end
      chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
      chk({tag, "_no_early_done"}, 64'(early_done), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'(exp_done));
      $display("txn %s op=%0d a=%h b=%h flush=%0b busy_cycles=%0d hi=%h lo=%h mul_res=%h done=%0b",
               tag, c, a, b, fl, n, hi, lo, mul_res, done);
   endtask

   task automatic next_cycle_done_low(input string tag);
      @(posedge clk); #1;
      chk({tag, "_done_pulse_end"}, 64'(done), 64'd0);
   endtask

   initial begin
      reset = 1'b1; op_valid = 1'b0; op = '0; op_a = '0; op_b = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      chk("rst_mulres", 64'(mul_res), 64'd0);
      @(negedge clk); reset = 1'b0;

      run_op("multu", 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 3, 1'b1);
      chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      next_cycle_done_low("multu");

      run_op("mult", 4'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 3, 1'b1);
      chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

      run_op("mul", 4'd6, 32'hFFFF_FFFF, 32'd3, 1'b0, 3, 1'b1);
      chk("mul_res", 64'(mul_res), 64'h0000_0000_FFFF_FFFD);
      chk("mul_hilo_kept", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

      run_op("div_neg", 4'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 1'b1);
      chk("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      next_cycle_done_low("div_neg");

      run_op("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
      chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

      run_op("divu", 4'd3, 32'd100, 32'd7, 1'b0, 33, 1'b1);
      chk("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

      run_op("divu_dz", 4'd3, 32'd5, 32'd0, 1'b0, 1, 1'b1);
      chk("divu_dz_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);

      run_op("flushed", 4'd3, 32'd10, 32'd3, 1'b1, 0, 1'b0);
      chk("flushed_hilo", {hi, lo}, 64'h0000_0005_FFFF_FFFF);

      run_op("mthi", 4'd4, 32'h0000_1234, 32'd0, 1'b0, 0, 1'b0);
      chk("mthi_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

      run_op("illegal7", 4'd7, 32'd1, 32'd1, 1'b0, 0, 1'b0);
      chk("illegal7_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

      // Reset in the middle of a divide
      @(negedge clk);
      op_valid = 1'b1; op = 4'd2; op_a = 32'd1000; op_b = 32'd3;
      @(negedge clk);
      op_valid = 1'b0;
      repeat (9) @(negedge clk);
      chk("midrst_busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_hilo", {hi, lo}, 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      chk("midrst_done_after", 64'(done), 64'd0);
      $display("txn midrst busy=%0b hi=%h lo=%h done=%0b", busy, hi, lo, done);

      run_op("mtlo", 4'd5, 32'd5, 32'd0, 1'b0, 0, 1'b0);
      chk("mtlo_hilo", {hi, lo}, 64'h0000_0000_0000_0005);
`ifdef XALU_MADD_EN
      run_op("madd", 4'd8, 32'd2, 32'd3, 1'b0, 3, 1'b1);
      chk("madd_hilo", {hi, lo}, 64'h0000_0000_0000_000B);
      run_op("msubu", 4'd11, 32'd4, 32'd4, 1'b0, 3, 1'b1);
      chk("msubu_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
`else
      run_op("madd", 4'd8, 32'd2, 32'd3, 1'b0, 0, 1'b0);
      chk("madd_hilo", {hi, lo}, 64'h0000_0000_0000_0005);
`endif

      chk("protocol_no_issue_while_busy", 64'(proto_viol), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
